// File: rtl/i4003_pshift.sv
// Shift register with parallel load and a strobed output latch, driven by cp/strobe
// events synchronised into the sysclk domain.
module i4003_pshift #(
    parameter int unsigned           WIDTH       = 10,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic                           sysclk,
    input  logic                           reset_n,
    input  logic                           cp,
    input  logic                           serial_in,
    input  logic                           dir,
    input  logic                           load,
    input  logic [WIDTH-1:0]               par_in,
    input  logic                           strobe,
    input  logic                           enable,
    output logic [WIDTH-1:0]               parallel_out,
    output logic                           serial_out,
    output logic [$clog2(WIDTH+1)-1:0]     count,
    output logic                           full
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             cp_meta, cp_sync, cp_prev, cp_armed;
    logic             st_meta, st_sync, st_prev, st_armed;
    logic             live;
    logic             cp_evt, st_evt, shift_evt, load_evt;
    logic [WIDTH-1:0] sr, latch, sr_nxt;
    logic [CW-1:0]    count_nxt;

    // Two-flop synchronisers plus edge detect. An input only arms once its
    // synchronised level has been seen low after reset, so a line held high
    // across reset release cannot fake a rising edge.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cp_meta  <= 1'b0;
            cp_sync  <= 1'b0;
            cp_prev  <= 1'b0;
            cp_armed <= 1'b0;
            st_meta  <= 1'b0;
            st_sync  <= 1'b0;
            st_prev  <= 1'b0;
            st_armed <= 1'b0;
            live     <= 1'b0;
        end else begin
            cp_meta  <= cp;
            cp_sync  <= cp_meta;
            cp_prev  <= cp_sync;
            cp_armed <= cp_armed | (live & ~cp_meta);
            st_meta  <= strobe;
            st_sync  <= st_meta;
            st_prev  <= st_sync;
            st_armed <= st_armed | (live & ~st_meta);
            live     <= 1'b1;
        end
    end

    assign cp_evt    = cp_sync & ~cp_prev & cp_armed;
    assign st_evt    = st_sync & ~st_prev & st_armed;
    assign load_evt  = cp_evt & load;
    assign shift_evt = cp_evt & ~load;

    // Next shift-register value and shift counter.
    always_comb begin
        sr_nxt    = sr;
        count_nxt = count;
        if (load_evt) begin
            sr_nxt = par_in;
        end else if (shift_evt) begin
            if (dir) begin
                sr_nxt = {serial_in, sr[WIDTH-1:1]};
            end else begin
                sr_nxt = {sr[WIDTH-2:0], serial_in};
            end
        end
        if (load_evt) begin
            count_nxt = '0;
        end else if (shift_evt && st_evt) begin
            count_nxt = CW'(1);
        end else if (shift_evt) begin
            if (count != CW'(WIDTH)) begin
                count_nxt = count + CW'(1);
            end
        end else if (st_evt) begin
            count_nxt = '0;
        end
    end

    // The latch captures the pre-update register contents.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sr    <= RESET_VALUE;
            latch <= RESET_VALUE;
            count <= '0;
            full  <= 1'b0;
        end else begin
            sr    <= sr_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CW'(WIDTH));
            if (st_evt) begin
                latch <= sr;
            end
        end
    end

    assign parallel_out = enable ? latch : '0;
    assign serial_out   = dir ? sr[0] : sr[WIDTH-1];

endmodule

// File: tb/tb_i4003_pshift.sv
// Directed bench for i4003_pshift: an event-scheduled reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_i4003_pshift;

    localparam int unsigned W  = 10;
    localparam int unsigned CW = $clog2(W + 1);

    logic          sysclk;
    logic          reset_n = 1'b1;
    logic          cp, serial_in, dir, load, strobe, enable;
    logic [W-1:0]  par_in;
    logic [W-1:0]  parallel_out;
    logic          serial_out;
    logic [CW-1:0] count;
    logic          full;

    int errors = 0;
    int checks = 0;

    // Scheduled actions: the driver records the sysclk cycle on which each
    // requested event must take effect (third edge after the rise).
    int           cyc    = 0;
    int           cp_due = -1;
    int           st_due = -1;
    logic         cp_ld, cp_dir, cp_si;
    logic [W-1:0] cp_par;

    logic [W-1:0] m_sr    = '0;
    logic [W-1:0] m_latch = '0;
    int           m_cnt   = 0;
    logic [W-1:0] m_pre;
    bit           m_do_cp, m_do_st;

    i4003_pshift #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .cp          (cp),
        .serial_in   (serial_in),
        .dir         (dir),
        .load        (load),
        .par_in      (par_in),
        .strobe      (strobe),
        .enable      (enable),
        .parallel_out(parallel_out),
        .serial_out  (serial_out),
        .count       (count),
        .full        (full)
    );

    initial begin
        sysclk = 1'b0;
        #10;
        forever #5 sysclk = ~sysclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model
    initial forever begin
        @(posedge sysclk or negedge reset_n);
        if (!reset_n) begin
            m_sr    = '0;
            m_latch = '0;
            m_cnt   = 0;
        end else begin
            cyc++;
            m_do_cp = (cp_due == cyc);
            m_do_st = (st_due == cyc);
            m_pre   = m_sr;
            if (m_do_cp) begin
                if (cp_ld)       m_sr = cp_par;
                else if (cp_dir) m_sr = (m_pre >> 1) | (W'(cp_si) << (W - 1));
                else             m_sr = (m_pre << 1) | W'(cp_si);
            end
            if (m_do_st) m_latch = m_pre;
            if (m_do_cp && cp_ld)  m_cnt = 0;
            else if (m_do_cp)      m_cnt = m_do_st ? 1 : ((m_cnt + 1 > W) ? W : m_cnt + 1);
            else if (m_do_st)      m_cnt = 0;
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge sysclk);
        chk("parallel_out", 32'(parallel_out), 32'(enable ? m_latch : '0));
        chk("serial_out", 32'(serial_out), 32'(dir ? m_sr[0] : m_sr[W-1]));
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == W));
        chk("sr", 32'(dut.sr), 32'(m_sr));
    end

    // One cp and/or strobe pulse; inputs stay stable until the action lands.
    task automatic pulse(input bit do_cp, input bit do_st, input logic ld,
                         input logic d, input logic si, input logic [W-1:0] p);
        @(posedge sysclk); #1;
        load = ld; dir = d; serial_in = si; par_in = p;
        if (do_cp) begin
            cp = 1'b1; cp_due = cyc + 3;
            cp_ld = ld; cp_dir = d; cp_si = si; cp_par = p;
        end
        if (do_st) begin
            strobe = 1'b1; st_due = cyc + 3;
        end
        @(posedge sysclk); #1;
        cp = 1'b0; strobe = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
    endtask

    logic [W-1:0] pat;

    initial begin
        cp = 0; strobe = 0; load = 0; dir = 0; serial_in = 0; par_in = '0; enable = 1;
        #2 reset_n = 1'b0;
        @(negedge sysclk); #1;
        chk("rst_po", 32'(parallel_out), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        @(posedge sysclk); #1 reset_n = 1'b1;
        repeat (3) @(posedge sysclk);

        // Serial fill, MSB-first pattern
        pat = 10'b1011001011;
        for (int i = 0; i < 10; i++) pulse(1, 0, 0, 0, pat[9-i], '0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'd10);
        chk("fill_sr", 32'(dut.sr), 32'(10'b1011001011));
        pulse(0, 1, 0, 0, 0, '0);
        chk("fill_po", 32'(parallel_out), 32'(10'b1011001011));
        chk("fill_count0", 32'(count), 32'h0);

        // Direction and cascade
        pulse(1, 0, 1, 0, 0, 10'h201);
        pulse(1, 0, 0, 1, 0, '0);
        chk("dir_sr1", 32'(dut.sr), 32'h100);
        chk("dir_so1", 32'(serial_out), 32'h0);
        pulse(1, 0, 0, 1, 0, '0);
        chk("dir_sr2", 32'(dut.sr), 32'h080);
        chk("dir_so2", 32'(serial_out), 32'h0);
        @(posedge sysclk); #1 dir = 1'b0;
        #1;
        chk("dir_so0", 32'(serial_out), 32'h0);
        chk("dir_msb", 32'(dut.sr[W-1]), 32'h0);

        // Load and strobe in the same detected cycle
        pulse(1, 0, 1, 0, 0, '0);
        pulse(1, 1, 1, 0, 0, 10'h3FF);
        chk("prio_latch", 32'(parallel_out), 32'h000);
        chk("prio_sr", 32'(dut.sr), 32'h3FF);
        chk("prio_count", 32'(count), 32'h0);

        // Saturation and enable gating
        for (int i = 0; i < 12; i++) pulse(1, 0, 0, 0, 1'(i % 2), '0);
        chk("sat_count", 32'(count), 32'd10);
        chk("sat_full", 32'(full), 32'h1);
        pulse(0, 1, 0, 0, 0, '0);
        chk("sat_po", 32'(parallel_out), 32'h155);
        @(posedge sysclk); #1 enable = 1'b0;
        #1 chk("en0_po", 32'(parallel_out), 32'h0);
        @(posedge sysclk); #1 enable = 1'b1;
        #1 chk("en1_po", 32'(parallel_out), 32'h155);

        // cp held high for 20 cycles gives one shift, three edges after the rise
        pulse(1, 0, 1, 0, 0, '0);
        @(posedge sysclk); #1;
        load = 0; dir = 0; serial_in = 1; cp = 1'b1;
        cp_ld = 0; cp_dir = 0; cp_si = 1; cp_par = '0; cp_due = cyc + 3;
        repeat (2) @(posedge sysclk);
        #1 chk("hold_e2", 32'(dut.sr), 32'h000);
        @(posedge sysclk);
        #1 chk("hold_e3", 32'(dut.sr), 32'h001);
        repeat (17) @(posedge sysclk);
        #1 chk("hold_sr", 32'(dut.sr), 32'h001);
        chk("hold_count", 32'(count), 32'h1);
        cp = 1'b0;
        repeat (3) @(posedge sysclk);

        // Reset mid-flight with cp and strobe high through release
        @(posedge sysclk); #1;
        serial_in = 1; cp = 1'b1; strobe = 1'b1;
        cp_due = cyc + 3; st_due = cyc + 3;
        @(posedge sysclk); #1;
        reset_n = 1'b0; cp_due = -1; st_due = -1;
        #2;
        chk("rst_sr", 32'(dut.sr), 32'h0);
        chk("rst_latch", 32'(parallel_out), 32'h0);
        chk("rst_cnt", 32'(count), 32'h0);
        repeat (2) @(posedge sysclk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge sysclk);
        #1;
        chk("post_sr", 32'(dut.sr), 32'h0);
        chk("post_cnt", 32'(count), 32'h0);
        chk("post_po", 32'(parallel_out), 32'h0);
        cp = 1'b0; strobe = 1'b0;
        repeat (3) @(posedge sysclk);
        pulse(1, 0, 0, 0, 1, '0);
        chk("rearm_sr", 32'(dut.sr), 32'h001);
        chk("rearm_cnt", 32'(count), 32'h1);
        pulse(0, 1, 0, 0, 0, '0);
        chk("rearm_po", 32'(parallel_out), 32'h001);

        repeat (2) @(posedge sysclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
